// File: rtl/me_search_ctrl_if.sv
// Candidate/result bus between the search controller, the reference fetch unit
// and the sad_cal datapath. The controller side is the master modport.
interface me_search_ctrl_if #(
    parameter int DWIDTH = 8,
    parameter int MVW    = 5
);
    logic                     cand_vld;
    logic signed [MVW-1:0]    cand_x;
    logic signed [MVW-1:0]    cand_y;
    logic                     ref_rdy;
    logic                     cal_en;
    logic [DWIDTH+7:0]        sad;
    logic                     sad_vld;

    modport master (
        output cand_vld, cand_x, cand_y, cal_en,
        input  ref_rdy, sad, sad_vld
    );

    modport slave (
        input  cand_vld, cand_x, cand_y, cal_en,
        output ref_rdy, sad, sad_vld
    );
endinterface

// File: rtl/me_search_ctrl.sv
// Full-search motion-estimation scheduler: walks every displacement of a +/-SR
// window in raster order, issues one cal_en beat per candidate, tracks the minimum SAD.
module me_search_ctrl #(
    parameter int DWIDTH     = 8,
    parameter int SR         = 8,
    parameter int MVW        = 5,
    parameter int PIPE_STAGE = 5
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    me_search_ctrl_if.master       bus,
    output logic                   busy,
    output logic                   done,
    output logic [DWIDTH+7:0]      best_sad,
    output logic signed [MVW-1:0]  best_mvx,
    output logic signed [MVW-1:0]  best_mvy
);
    localparam int N  = (2 * SR + 1) * (2 * SR + 1);
    localparam int CW = $clog2(N + 1);
    localparam int SW = DWIDTH + 8;

    localparam logic signed [MVW-1:0] C_POS = MVW'(SR);
    localparam logic signed [MVW-1:0] C_NEG = -C_POS;
    localparam logic [CW-1:0]         C_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic signed [MVW-1:0] r_cand_x, w_cand_x_nxt;
    logic signed [MVW-1:0] r_cand_y, w_cand_y_nxt;
    logic [CW-1:0]         r_issue_cnt, w_issue_cnt_nxt;
    logic signed [MVW-1:0] r_ret_x, w_ret_x_nxt;
    logic signed [MVW-1:0] r_ret_y, w_ret_y_nxt;
    logic [CW-1:0]         r_ret_cnt, w_ret_cnt_nxt;
    logic                  r_first, w_first_nxt;
    logic [SW-1:0]         r_best_sad, w_best_sad_nxt;
    logic signed [MVW-1:0] r_best_mvx, w_best_mvx_nxt;
    logic signed [MVW-1:0] r_best_mvy, w_best_mvy_nxt;

    logic w_cand_vld;
    logic w_cal_en;
    logic w_track;

    assign w_cand_vld = (r_state == S_ISSUE);
    assign w_cal_en   = w_cand_vld & bus.ref_rdy;
    assign w_track    = (r_state == S_ISSUE) || (r_state == S_DRAIN);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_cand_x    <= '0;
            r_cand_y    <= '0;
            r_issue_cnt <= '0;
            r_ret_x     <= '0;
            r_ret_y     <= '0;
            r_ret_cnt   <= '0;
            r_first     <= 1'b0;
            r_best_sad  <= '0;
            r_best_mvx  <= '0;
            r_best_mvy  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cand_x    <= w_cand_x_nxt;
            r_cand_y    <= w_cand_y_nxt;
            r_issue_cnt <= w_issue_cnt_nxt;
            r_ret_x     <= w_ret_x_nxt;
            r_ret_y     <= w_ret_y_nxt;
            r_ret_cnt   <= w_ret_cnt_nxt;
            r_first     <= w_first_nxt;
            r_best_sad  <= w_best_sad_nxt;
            r_best_mvx  <= w_best_mvx_nxt;
            r_best_mvy  <= w_best_mvy_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cand_x_nxt    = r_cand_x;
        w_cand_y_nxt    = r_cand_y;
        w_issue_cnt_nxt = r_issue_cnt;
        w_ret_x_nxt     = r_ret_x;
        w_ret_y_nxt     = r_ret_y;
        w_ret_cnt_nxt   = r_ret_cnt;
        w_first_nxt     = r_first;
        w_best_sad_nxt  = r_best_sad;
        w_best_mvx_nxt  = r_best_mvx;
        w_best_mvy_nxt  = r_best_mvy;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_cand_x_nxt    = C_NEG;
                    w_cand_y_nxt    = C_NEG;
                    w_issue_cnt_nxt = '0;
                    w_ret_x_nxt     = C_NEG;
                    w_ret_y_nxt     = C_NEG;
                    w_ret_cnt_nxt   = '0;
                    w_first_nxt     = 1'b1;
                    w_state_nxt     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // The last candidate stays on cand_x/cand_y after its beat.
                if (w_cal_en) begin
                    w_issue_cnt_nxt = r_issue_cnt + CW'(1);
                    if (r_issue_cnt == C_LAST) begin
                        w_state_nxt = S_DRAIN;
                    end else if (r_cand_x == C_POS) begin
                        w_cand_x_nxt = C_NEG;
                        w_cand_y_nxt = r_cand_y + MVW'(1);
                    end else begin
                        w_cand_x_nxt = r_cand_x + MVW'(1);
                    end
                end
            end
            S_DRAIN: begin
                w_state_nxt = S_DRAIN;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Results come back in issue order, so a second raster walker names them.
        if (w_track && bus.sad_vld) begin
            w_ret_cnt_nxt = r_ret_cnt + CW'(1);
            if (r_ret_x == C_POS) begin
                w_ret_x_nxt = C_NEG;
                w_ret_y_nxt = r_ret_y + MVW'(1);
            end else begin
                w_ret_x_nxt = r_ret_x + MVW'(1);
            end
            // Strict compare: a later equal SAD never displaces an earlier one.
            if (r_first || (bus.sad < r_best_sad)) begin
                w_best_sad_nxt = bus.sad;
                w_best_mvx_nxt = r_ret_x;
                w_best_mvy_nxt = r_ret_y;
            end
            w_first_nxt = 1'b0;
            if (r_ret_cnt == C_LAST) begin
                w_state_nxt = S_DONE;
            end
        end
    end

    assign bus.cand_vld = w_cand_vld;
    assign bus.cand_x   = r_cand_x;
    assign bus.cand_y   = r_cand_y;
    assign bus.cal_en   = w_cal_en;

    assign busy     = w_track;
    assign done     = (r_state == S_DONE);
    assign best_sad = r_best_sad;
    assign best_mvx = r_best_mvx;
    assign best_mvy = r_best_mvy;
endmodule

// File: tb/tb_me_search_ctrl.sv
// Bench for me_search_ctrl with SR=2 (25 candidates) and a 5-deep behavioral SAD
// source that returns a per-candidate table value.
module tb_me_search_ctrl;
    localparam int DW  = 8;
    localparam int SR  = 2;
    localparam int MVW = 5;
    localparam int L   = 5;
    localparam int N   = (2 * SR + 1) * (2 * SR + 1);
    localparam int SW  = DW + 8;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic start = 1'b0;
    logic busy, done;
    logic [SW-1:0] best_sad;
    logic signed [MVW-1:0] best_mvx, best_mvy;

    always #5 clk = ~clk;

    me_search_ctrl_if #(.DWIDTH(DW), .MVW(MVW)) bus ();

    me_search_ctrl #(
        .DWIDTH(DW), .SR(SR), .MVW(MVW), .PIPE_STAGE(L)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .start(start),
        .bus(bus),
        .busy(busy),
        .done(done),
        .best_sad(best_sad),
        .best_mvx(best_mvx),
        .best_mvy(best_mvy)
    );

    // SAD table: base value everywhere, with up to two special entries.
    int base_v = 0;
    int sp_x = 99, sp_y = 99, sp_v = 0;
    int sp2_x = 99, sp2_y = 99, sp2_v = 0;
    logic stray_vld = 1'b0;
    logic [SW-1:0] stray_sad = '0;

    function automatic logic [SW-1:0] sad_of(input int x, input int y);
        if (x == sp_x && y == sp_y) return SW'(sp_v);
        if (x == sp2_x && y == sp2_y) return SW'(sp2_v);
        return SW'(base_v);
    endfunction

    logic          pv [L];
    logic [SW-1:0] pd [L];

    always @(posedge clk) begin
        pv[0] <= bus.cal_en;
        pd[0] <= sad_of($signed(bus.cand_x), $signed(bus.cand_y));
        for (int i = 1; i < L; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
        end
    end

    assign bus.sad_vld = pv[L-1] | stray_vld;
    assign bus.sad     = stray_vld ? stray_sad : pd[L-1];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        string name;
        int base;
        int sx, sy, sv;
        int s2x, s2y, s2v;
        int stall;
        int exp_sad, exp_x, exp_y;
        int exp_cyc;   // edge count from the start edge to the edge that first samples done=1
    } vec_t;

    vec_t vecs[6];

    task automatic load_table(input vec_t v);
        base_v = v.base;
        sp_x = v.sx;   sp_y = v.sy;   sp_v = v.sv;
        sp2_x = v.s2x; sp2_y = v.s2y; sp2_v = v.s2v;
    endtask

    task automatic run_search(input vec_t v, input bit poke);
        int cyc, beats, order_err, hold_err, busy_err, ex, ey, hx, hy;
        bit held, seen;
        cyc = 0; beats = 0; order_err = 0; hold_err = 0; busy_err = 0;
        ex = -SR; ey = -SR; hx = 0; hy = 0; held = 0; seen = 0;
        load_table(v);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < 300) begin
            bus.ref_rdy = (v.stall == 0) ? 1'b1 : ((cyc % 2) == 0);
            start = poke && (cyc == 4 || cyc == 27);
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
            if (!busy) busy_err++;
            if (held && ($signed(bus.cand_x) != hx || $signed(bus.cand_y) != hy)) hold_err++;
            held = bus.cand_vld && !bus.ref_rdy;
            hx = $signed(bus.cand_x);
            hy = $signed(bus.cand_y);
            if (bus.cal_en) begin
                if ($signed(bus.cand_x) != ex || $signed(bus.cand_y) != ey) order_err++;
                beats++;
                if (ex == SR) begin
                    ex = -SR;
                    ey++;
                end else begin
                    ex++;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        bus.ref_rdy = 1'b1;
        chk({v.name, " done_seen"}, int'(seen), 1);
        chk({v.name, " done_cycle"}, cyc + 1, v.exp_cyc);
        chk({v.name, " beats"}, beats, N);
        chk({v.name, " raster_order_errs"}, order_err, 0);
        chk({v.name, " stall_hold_errs"}, hold_err, 0);
        chk({v.name, " busy_low_errs"}, busy_err, 0);
        chk({v.name, " busy_in_done"}, int'(busy), 0);
        chk({v.name, " best_sad"}, int'(best_sad), v.exp_sad);
        chk({v.name, " best_mvx"}, int'(best_mvx), v.exp_x);
        chk({v.name, " best_mvy"}, int'(best_mvy), v.exp_y);
        $display("search %s: done at edge %0d, %0d beats, best_sad=%0d mv=(%0d,%0d)",
                 v.name, cyc + 1, beats, best_sad, best_mvx, best_mvy);
        @(posedge clk); #1;
        @(negedge clk);
        chk({v.name, " done_pulse_width"}, int'(done), 0);
        chk({v.name, " best_hold"}, int'(best_sad), v.exp_sad);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, bad;
        vecs[0] = '{"t1_min_mid",     100,  1, -1, 7,     99, 99, 0,     0, 7,     1, -1, N + L + 1};
        vecs[1] = '{"t2_all_equal",   50,   99, 99, 0,    99, 99, 0,     0, 50,   -2, -2, N + L + 1};
        vecs[2] = '{"t3_stall",       100,  1, -1, 7,     99, 99, 0,     1, 7,     1, -1, N + L + 1 + (N - 1)};
        vecs[3] = '{"t4_min_last",    100,  2, 2, 0,      99, 99, 0,     0, 0,     2, 2,  N + L + 1};
        vecs[4] = '{"tie_two_mins",   80,  -1, 0, 3,      1, 1, 3,       0, 3,    -1, 0,  N + L + 1};
        vecs[5] = '{"unsigned_cmp",   40000, 0, 0, 30000, -2, 2, 50000,  0, 30000, 0, 0,  N + L + 1};

        bus.ref_rdy = 1'b1;
        @(negedge clk);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset cand_vld", int'(bus.cand_vld), 0);
        chk("reset cal_en", int'(bus.cal_en), 0);
        chk("reset cand_x", int'(bus.cand_x), 0);
        chk("reset best_sad", int'(best_sad), 0);
        chk("reset best_mvy", int'(best_mvy), 0);
        repeat (8) @(posedge clk);
        #1 rstn = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_search(vecs[i], 1'b0);
        end

        // Stray result in IDLE must not touch best_*, then restart pokes are ignored.
        @(posedge clk); #1;
        stray_vld = 1'b1;
        stray_sad = '0;
        @(posedge clk); #1;
        stray_vld = 1'b0;
        @(negedge clk);
        chk("stray busy", int'(busy), 0);
        chk("stray best_sad", int'(best_sad), 30000);
        chk("stray best_mvx", int'(best_mvx), 0);
        vecs[0].name = "t5_start_pokes";
        run_search(vecs[0], 1'b1);

        // Reset mid-search at beat 10, with results still in flight.
        load_table(vecs[0]);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cnt = 0;
        for (int c = 0; c < 50 && cnt < 10; c++) begin
            @(negedge clk);
            if (bus.cal_en) cnt++;
            @(posedge clk); #1;
        end
        chk("t6 beats_before_reset", cnt, 10);
        rstn = 1'b0;
        @(negedge clk);
        chk("t6 reset done", int'(done), 0);
        chk("t6 reset busy", int'(busy), 0);
        chk("t6 reset cal_en", int'(bus.cal_en), 0);
        chk("t6 reset cand_y", int'(bus.cand_y), 0);
        chk("t6 reset best_sad", int'(best_sad), 0);
        @(posedge clk);
        @(posedge clk); #1;
        rstn = 1'b1;
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (busy || done) bad++;
            @(posedge clk); #1;
        end
        chk("t6 idle_after_release_errs", bad, 0);
        chk("t6 stale_results_ignored", int'(best_sad), 0);
        vecs[0].name = "t6_after_reset";
        run_search(vecs[0], 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
